// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: issues LEN operand addresses to a ce-gated multiplier
// pipeline, tags each issue, and accumulates the returning products.
module mac_seq_ctrl #(
    parameter int CNT_W   = 8,
    parameter int PROD_W  = 26,
    parameter int ACC_W   = 32,
    parameter int RD_LAT  = 1,
    parameter int MUL_LAT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         len,
    output logic                     busy,
    output logic [CNT_W-1:0]         addr,
    output logic                     mul_ce,
    input  logic signed [PROD_W-1:0] prod,
    output logic signed [ACC_W-1:0]  acc_out,
    output logic                     ovf,
    output logic                     out_valid,
    input  logic                     out_ready
);

    localparam int PIPE_LAT = RD_LAT + MUL_LAT;
    localparam logic [PIPE_LAT-1:0] TAG_LAST = PIPE_LAT'(1) << (PIPE_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_HOLD
    } state_e;

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          idx_q, idx_d;
    logic [CNT_W-1:0]          len_q, len_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic                      ovf_q, ovf_d;
    logic [PIPE_LAT-1:0]       tag_q, tag_d;
    logic                      tag_in;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   sum;
    logic                      sum_ovf;

    assign prod_ext = ACC_W'(prod);
    assign sum      = acc_q + prod_ext;
    // Same-sign addends whose sum flips sign have wrapped.
    assign sum_ovf  = (acc_q[ACC_W-1] == prod_ext[ACC_W-1]) &&
                      (sum[ACC_W-1] != acc_q[ACC_W-1]);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        len_d     = len_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        tag_d     = tag_q;
        tag_in    = 1'b0;
        mul_ce    = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = len;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    tag_d   = '0;
                    state_d = (len != '0) ? S_ISSUE : S_HOLD;
                end
            end
            S_ISSUE: begin
                mul_ce = 1'b1;
                tag_in = 1'b1;
                if (idx_q == len_q - CNT_W'(1)) begin
                    state_d = S_DRAIN;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                mul_ce = 1'b1;
                if (tag_q == TAG_LAST) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mul_ce) begin
            tag_d = {tag_q[PIPE_LAT-2:0], tag_in};
            if (tag_q[PIPE_LAT-1]) begin
                acc_d = sum;
                ovf_d = ovf_q | sum_ovf;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            tag_q   <= tag_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign addr    = idx_q;
    assign acc_out = acc_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: behavioural memory+multiplier pipeline, vector table,
// scoreboard of expected results, and hand-written corner sequences.
module tb_mac_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic               start, out_ready;
    logic [7:0]         len;
    logic               busy, mul_ce, ovf, out_valid;
    logic [7:0]         addr;
    logic signed [25:0] prod;
    logic signed [31:0] acc_out;

    logic              start8, rdy8, busy8, mul_ce8, ovf8, ov8;
    logic [7:0]        len8, addr8;
    logic signed [7:0] prod8, acc8;

    mac_seq_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .busy(busy), .addr(addr), .mul_ce(mul_ce), .prod(prod),
        .acc_out(acc_out), .ovf(ovf), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    mac_seq_ctrl #(.PROD_W(8), .ACC_W(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .len(len8),
        .busy(busy8), .addr(addr8), .mul_ce(mul_ce8), .prod(prod8),
        .acc_out(acc8), .ovf(ovf8), .out_valid(ov8),
        .out_ready(rdy8)
    );

    // External operand memory (1 cycle) + 4-stage multiplier, both ce-gated.
    logic signed [25:0] mem  [256];
    logic signed [25:0] pipe [5];
    logic signed [7:0]  mem8 [256];
    logic signed [7:0]  pipe8[5];

    always @(posedge clk) begin
        if (mul_ce) begin
            pipe[0] <= mem[addr];
            for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
        end
        if (mul_ce8) begin
            pipe8[0] <= mem8[addr8];
            for (int i = 1; i < 5; i++) pipe8[i] <= pipe8[i-1];
        end
    end
    assign prod  = pipe[4];
    assign prod8 = pipe8[4];

    typedef struct {
        logic signed [31:0] acc;
        logic               ov;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        int     n;
        int     p[4];
        longint eacc;
        bit     eovf;
        int     ecyc;
        int     hold;
        bit     noise;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference sum: exact arithmetic, then wrap to 32 bits; overflow when
    // any partial sum leaves the signed 32-bit range.
    task automatic model(input int n, output longint acc, output bit ov);
        longint a;
        longint s;
        logic [31:0] t;
        a  = 0;
        ov = 1'b0;
        for (int k = 0; k < n; k++) begin
            s = a + longint'(mem[k]);
            if (s > 64'sd2147483647 || s < -64'sd2147483648) ov = 1'b1;
            t = s[31:0];
            a = longint'(signed'(t));
        end
        acc = a;
    endtask

    task automatic run_op(input int n, input int hold, input bit noise,
                          input int ecyc, input longint eacc, input bit eovf);
        int   cyc, mce, aerr, berr, serr, ea;
        bit   got;
        exp_t e;
        logic signed [31:0] a0;
        logic o0;
        @(negedge clk);
        start = 1'b1;
        len   = 8'(n);
        sbq.push_back('{acc: 32'(eacc), ov: eovf});
        @(posedge clk);
        cyc = 0; mce = 0; aerr = 0; berr = 0; got = 1'b0;
        forever begin
            @(negedge clk);
            if (cyc == 0) len = 8'(n + 3);
            start = 1'b0;
            if (mul_ce) mce++;
            ea = (n == 0) ? 0 : ((cyc < n - 1) ? cyc : n - 1);
            if (int'(addr) != ea) aerr++;
            if (!busy) berr++;
            if (out_valid) begin
                got = 1'b1;
                break;
            end
            if (cyc >= 400) break;
            if (noise && (cyc == 2 || cyc == n + 3)) start = 1'b1;
            @(posedge clk);
            cyc++;
        end
        chk("latency", got ? longint'(cyc) : -1, longint'(ecyc));
        chk("mul_ce_cycles", longint'(mce), (n == 0) ? 0 : longint'(n + 5));
        chk("addr_seq_errs", longint'(aerr), 0);
        chk("busy_run_errs", longint'(berr), 0);
        if (!got) begin
            reset = 1'b0;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            e = sbq.pop_front();
            return;
        end
        a0 = acc_out;
        o0 = ovf;
        serr = 0;
        for (int h = 0; h < hold; h++) begin
            if (noise && h == 1) start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            if (!out_valid || acc_out != a0 || ovf != o0 || !busy) serr++;
        end
        if (hold > 0) chk("hold_stable_errs", longint'(serr), 0);
        e = sbq.pop_front();
        chk("acc_out", longint'(acc_out), longint'(e.acc));
        chk("ovf", longint'(ovf), longint'(e.ov));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("valid_drop", longint'(out_valid), 0);
        chk("busy_drop", longint'(busy), 0);
        chk("addr_idle", longint'(addr), 0);
        if (noise) begin
            serr = 0;
            repeat (4) begin
                @(posedge clk);
                @(negedge clk);
                if (out_valid || busy) serr++;
            end
            chk("no_extra_result", longint'(serr), 0);
        end
    endtask

    task automatic run8(input int n, input longint eacc, input bit eovf);
        int cyc;
        @(negedge clk);
        start8 = 1'b1;
        len8   = 8'(n);
        cyc    = 0;
        do begin
            @(posedge clk);
            @(negedge clk);
            start8 = 1'b0;
            cyc++;
        end while (!ov8 && cyc < 50);
        chk("w8_valid", longint'(ov8), 1);
        chk("w8_acc_out", longint'(acc8), eacc);
        chk("w8_ovf", longint'(ovf8), longint'(eovf));
        rdy8 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rdy8 = 1'b0;
        chk("w8_valid_drop", longint'(ov8), 0);
    endtask

    vec_t   vecs[7];
    longint macc;
    bit     movf;

    initial begin
        vecs[0] = '{3, '{10, -4, 7, 0},         13,         0, 8, 0, 0};
        vecs[1] = '{0, '{0, 0, 0, 0},           0,          0, 0, 0, 0};
        vecs[2] = '{2, '{1000, -3000, 0, 0},    -2000,      0, 7, 5, 0};
        vecs[3] = '{4, '{-100, -200, 300, -1},  -1,         0, 9, 3, 1};
        vecs[4] = '{2, '{33554431, 33554431, 0, 0}, 67108862, 0, 7, 0, 0};
        vecs[5] = '{4, '{-33554432, -33554432, -33554432, -33554432},
                    -134217728, 0, 9, 1, 0};
        vecs[6] = '{1, '{5, 0, 0, 0},           5,          0, 6, 0, 0};

        reset = 1'b0;
        start = 1'b0; len = '0; out_ready = 1'b0;
        start8 = 1'b0; len8 = '0; rdy8 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            mem[i]  = 26'(i * 3 + 1);
            mem8[i] = 8'(i);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_addr", longint'(addr), 0);
        chk("rst_mul_ce", longint'(mul_ce), 0);
        chk("rst_acc_out", longint'(acc_out), 0);
        chk("rst_ovf", longint'(ovf), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_w8_valid", longint'(ov8), 0);
        reset = 1'b1;

        foreach (vecs[v]) begin
            for (int i = 0; i < 4; i++) mem[i] = 26'(vecs[v].p[i]);
            run_op(vecs[v].n, vecs[v].hold, vecs[v].noise,
                   vecs[v].ecyc, vecs[v].eacc, vecs[v].eovf);
        end

        for (int i = 0; i < 256; i++) mem[i] = -26'sd33554432;
        model(255, macc, movf);
        run_op(255, 0, 0, 260, macc, movf);

        // Abort mid-issue: stale products remain in the multiplier pipe.
        for (int i = 0; i < 6; i++) mem[i] = 26'(77 + i);
        @(negedge clk);
        start = 1'b1;
        len   = 8'd6;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("abort_idx", longint'(addr), 2);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_addr", longint'(addr), 0);
        chk("abort_mul_ce", longint'(mul_ce), 0);
        chk("abort_acc_out", longint'(acc_out), 0);
        chk("abort_ovf", longint'(ovf), 0);
        chk("abort_out_valid", longint'(out_valid), 0);
        reset = 1'b1;
        mem[0] = 26'sd5;
        run_op(1, 0, 0, 6, 5, 0);

        mem8[0] = 8'sd100;
        mem8[1] = 8'sd100;
        run8(2, -56, 1);
        mem8[0] = 8'sd1;
        run8(1, 1, 0);

        chk("sb_empty", longint'(sbq.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
Name: mac_seq_ctrl

Overview:
- Sequencer that computes one dot product of LEN terms using an external fixed-latency, ce-gated signed multiplier pipeline.
- Each cycle it issues one element address to the weight and activation memories, which feed the multiplier directly.
- It tags each issued element through a shadow valid pipeline, accumulates the returning products, and presents the sum on a valid/ready output.
- Sits between the layer loop control (start/len) and the multiplier in the layer-3 convolution datapath.

Parameters:
- CNT_W, 8: width of len and addr; maximum len is 2^CNT_W-1.
- PROD_W, 26: multiplier product width, signed.
- ACC_W, 32: accumulator width, signed, ACC_W >= PROD_W.
- RD_LAT, 1: operand memory read latency in cycles.
- MUL_LAT, 4: multiplier register stages (input register plus 3 output buffers).
- PIPE_LAT: derived, RD_LAT+MUL_LAT (default 5); not user-set.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  request a new dot product; sampled only in IDLE.
- len  in  CNT_W  number of terms; sampled with start.
- busy  out  1  high in every state except IDLE.
- addr  out  CNT_W  element index to both operand memories.
- mul_ce  out  1  clock enable to the multiplier pipeline.
- prod  in  PROD_W  signed multiplier output.
- acc_out  out  ACC_W  signed dot-product result.
- ovf  out  1  sticky signed-overflow flag for the current result.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumer ready.

Behaviour:
- Reset (reset=0 at an edge): state IDLE; idx, acc, ovf and the tag pipeline cleared. Outputs: busy=0, addr=0, mul_ce=0, acc_out=0, ovf=0, out_valid=0. Reset mid-operation aborts immediately; in-flight tags are discarded and no result is produced.
- States:
  - IDLE:
    - start=1, len!=0 -> ISSUE; idx=0, acc=0, ovf=0.
    - start=1, len=0 -> HOLD with acc=0, ovf=0.
  - ISSUE:
    - addr=idx; mul_ce=1; a tag of 1 is pushed into tag stage 0 at the edge.
    - idx increments each cycle.
    - When idx==len_r-1 the element is issued and the state moves to DRAIN.
  - DRAIN:
    - mul_ce=1; a tag of 0 is pushed; addr holds its last value.
    - Moves to HOLD at the edge where the final tag is accumulated.
  - HOLD:
    - out_valid=1; acc_out and ovf are stable; mul_ce=0.
    - out_valid && out_ready -> IDLE, with out_valid low on the next cycle.
- start is ignored outside IDLE. len is latched into len_r on acceptance, so later changes to len have no effect.
- Tag pipeline:
  - PIPE_LAT stages, shifting only when mul_ce=1.
  - While the last stage holds a 1, prod is valid.
  - At that edge, acc <= acc + sign-extended prod, modulo 2^ACC_W.
- Overflow: ovf is set when both addends have equal sign and the sum's sign differs. It stays set (sticky) until the next accepted start.
- Timing, with start accepted at edge E0:
  - Element k is issued in the cycle after E(k).
  - Element k is accumulated at edge E(k+PIPE_LAT+1).
  - out_valid is first high after edge E(len+PIPE_LAT); for len=3 with defaults, that is 8 cycles after E0.
- Throughput: one term per cycle, no bubbles within an operation. There is one idle cycle between a result handshake and the next start being accepted.
- len = 2^CNT_W-1: idx reaches the maximum value without wrapping; no extra element is issued.

Test Plan:
- Defaults, len=3, prod stream 10, -4, 7 aligned to tags -> addr sequence 0, 1, 2; mul_ce high for 8 cycles; out_valid high 8 cycles after start; acc_out=13; ovf=0.
- start with len=0 -> out_valid the cycle after start; acc_out=0; mul_ce never asserted; addr stays 0.
- len=2 result, out_ready held low for 5 cycles -> out_valid and acc_out stable throughout; returns to IDLE one cycle after out_ready=1; busy falls at the same time.
- ACC_W=PROD_W=8, len=2, prods 100, 100 -> acc_out=-56 (wrapped); ovf=1. A following run with prod 1 gives acc_out=1 and ovf=0.
- reset=0 during ISSUE at idx=2 of len=6 -> next cycle all outputs are at reset values; a new start with len=1, prod=5 then yields acc_out=5 with no stale contributions.
- start pulsed in ISSUE, DRAIN and HOLD -> ignored; only one result is produced; len changes after acceptance have no effect.
